// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single VRAM port between the PPU renderer and the CPU-side
// register interface ($2007 traffic). The renderer always wins. A CPU access
// is held in a one-deep buffer and issued in a cycle the renderer leaves
// free. If the renderer is in a visible window for STARVE_LIMIT pending
// cycles, the visible-window block is lifted so the CPU can still get in.
//
// Ports
//   VGA_CLK, reset            clock, asynchronous active-high reset
//   render_active             renderer in a visible-scanline window
//   rnd_req, rnd_addr         renderer read request and address
//   rnd_data, rnd_valid       renderer read data (last cycle's request)
//   cpu_req, cpu_we,          one-cycle CPU access strobe with direction,
//   cpu_addr, cpu_wdata       address and write data
//   cpu_busy                  pending buffer occupied
//   cpu_ack                   one-cycle completion pulse
//   cpu_rdata                 last CPU read data, held until the next read
//   cpu_overrun               sticky: a cpu_req arrived while busy
//   vram_addr, vram_we,       VRAM port; vram_dout is valid one cycle after
//   vram_din, vram_dout       the address is presented
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 32
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic              render_active,
  input  logic              rnd_req,
  input  logic [ADDR_W-1:0] rnd_addr,
  output logic [DATA_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_overrun,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_din,
  input  logic [DATA_W-1:0] vram_dout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] ACK  = 2'd3;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic [7:0]        stall_cnt;
  logic              eligible;
  logic              grant;
  logic              capture;

  // A renderer request always blocks the CPU, even once it is starved; the
  // visible-window block only lifts after LIMIT stalled cycles.
  assign eligible = !rnd_req && (!render_active || (stall_cnt == LIMIT));
  assign grant    = (state == PEND) && eligible;
  assign capture  = cpu_req && ((state == IDLE) || (state == ACK));

  // Next-state logic: the ACK cycle accepts a new request so back-to-back
  // traffic runs at one access every three cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = PEND;
      PEND:    if (grant) state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = cpu_req ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The async reset on the state register is what drops vram_we at once:
  // grant is decoded from state, so leaving PEND kills the write enable.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // One-deep request buffer, loaded only when no access is outstanding.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else if (capture) begin
      buf_we    <= cpu_we;
      buf_addr  <= cpu_addr;
      buf_wdata <= cpu_wdata;
    end
  end

  // Counts cycles the buffered access has been refused; saturating keeps
  // the starved condition stable until the renderer leaves a gap.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (grant || capture) begin
      stall_cnt <= '0;
    end else if ((state == PEND) && (stall_cnt != LIMIT)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // A request while the buffer is occupied is lost; remember that it happened.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      cpu_overrun <= 1'b0;
    end else if (cpu_req && ((state == PEND) || (state == WAIT))) begin
      cpu_overrun <= 1'b1;
    end
  end

  // Read data returns during WAIT and is held for the CPU until the next read.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
    end else if ((state == WAIT) && !buf_we) begin
      cpu_rdata <= vram_dout;
    end
  end

  // The renderer's data is always one cycle behind its request.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) rnd_valid <= 1'b0;
    else       rnd_valid <= rnd_req;
  end

  assign rnd_data  = vram_dout;
  assign cpu_busy  = (state == PEND) || (state == WAIT);
  assign cpu_ack   = (state == ACK);
  assign vram_addr = grant ? buf_addr : rnd_addr;
  assign vram_we   = grant && buf_we;
  assign vram_din  = grant ? buf_wdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter. Holds a behavioural VRAM (registered
// read, write at the clock edge), a directed vector table, hand-written
// reset / starvation / back-to-back sequences, and a randomized phase
// checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int STARVE_LIMIT = 32;

  logic        VGA_CLK;
  logic        reset;
  logic        render_active;
  logic        rnd_req;
  logic [15:0] rnd_addr;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_busy;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_overrun;
  logic [15:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;

  logic        pre_en;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];

  int pass_cnt;
  int total_cnt;

  vram_arbiter #(
    .ADDR_W(16),
    .DATA_W(8),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .VGA_CLK(VGA_CLK),
    .reset(reset),
    .render_active(render_active),
    .rnd_req(rnd_req),
    .rnd_addr(rnd_addr),
    .rnd_data(rnd_data),
    .rnd_valid(rnd_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_overrun(cpu_overrun),
    .vram_addr(vram_addr),
    .vram_we(vram_we),
    .vram_din(vram_din),
    .vram_dout(vram_dout)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  // Behavioural VRAM: read data appears one cycle after the address.
  always @(posedge VGA_CLK) begin
    if (pre_en)       mem[pre_addr]  <= pre_data;
    else if (vram_we) mem[vram_addr] <= vram_din;
    vram_dout <= mem[vram_addr];
  end

  typedef struct {
    logic        rr;
    logic        ra;
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [7:0]  cd;
    logic [15:0] radr;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_din;
    logic        e_busy;
    logic        e_ack;
    logic        e_ovr;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic rr, ra, cr, cw, input logic [15:0] ca,
                              input logic [7:0] cd, input logic [15:0] radr,
                              input logic [15:0] e_addr, input logic e_we,
                              input logic [7:0] e_din, input logic e_busy, e_ack,
                              e_ovr, input logic [7:0] e_rdata);
    vec_t v;
    v.rr = rr; v.ra = ra; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.radr = radr; v.e_addr = e_addr; v.e_we = e_we; v.e_din = e_din;
    v.e_busy = e_busy; v.e_ack = e_ack; v.e_ovr = e_ovr; v.e_rdata = e_rdata;
    return v;
  endfunction

  function automatic logic [7:0] preVal(input int i);
    return (i == 0) ? 8'h5A : 8'(i * 17 + 3);
  endfunction

  // Drive one cycle's inputs after the falling edge, then let them settle.
  task automatic applyStimulus(input logic rr, ra, cr, cw, input logic [15:0] ca,
                               input logic [7:0] cd, input logic [15:0] radr);
    @(negedge VGA_CLK);
    rnd_req       = rr;
    render_active = ra;
    cpu_req       = cr;
    cpu_we        = cw;
    cpu_addr      = ca;
    cpu_wdata     = cd;
    rnd_addr      = radr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reset with the clock running and preload the 0x2000..0x200F window.
  task automatic doReset();
    reset = 1'b1;
    rnd_req = 1'b0; render_active = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; rnd_addr = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge VGA_CLK);
      pre_en   = 1'b1;
      pre_addr = 16'h2000 + 16'(i);
      pre_data = preVal(i);
      ref_mem[16'h2000 + 16'(i)] = preVal(i);
    end
    @(negedge VGA_CLK);
    pre_en = 1'b0;
    reset  = 1'b0;
  endtask

  logic        rr, ra, cr, cw, prev_rr;
  logic [15:0] ca, radr, prev_radr;
  logic [7:0]  cd;
  logic        eg, ea, eb;
  logic        granted;
  int          waited, gcyc, k;
  logic        m_valid, m_we, m_granted, m_ovr;
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_rdata;
  int          m_waited, m_gcyc;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // ---- reset values ----
    doReset();
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0, 16'h1234);
    checkOutput("reset busy", cpu_busy, 0);
    checkOutput("reset ack", cpu_ack, 0);
    checkOutput("reset rdata", cpu_rdata, 0);
    checkOutput("reset overrun", cpu_overrun, 0);
    checkOutput("reset rnd_valid", rnd_valid, 0);
    checkOutput("reset vram_we", vram_we, 0);
    checkOutput("reset vram_addr", vram_addr, 16'h1234);

    // ---- directed table: idle read, write under priority, readback, overrun ----
    doReset();
    vecs[0]  = mk(0,0,1,0,16'h2000,8'h00,16'h2005, 16'h2005,0,8'h00,0,0,0,8'h00);
    vecs[1]  = mk(0,0,0,0,16'h0000,8'h00,16'h2005, 16'h2000,0,8'h00,1,0,0,8'h00);
    vecs[2]  = mk(0,0,0,0,16'h0000,8'h00,16'h2005, 16'h2005,0,8'h00,1,0,0,8'h00);
    vecs[3]  = mk(0,0,0,0,16'h0000,8'h00,16'h2005, 16'h2005,0,8'h00,0,1,0,8'h5A);
    vecs[4]  = mk(1,0,1,1,16'h23C0,8'h77,16'h2006, 16'h2006,0,8'h00,0,0,0,8'h5A);
    vecs[5]  = mk(1,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,1,0,0,8'h5A);
    vecs[6]  = mk(1,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,1,0,0,8'h5A);
    vecs[7]  = mk(1,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,1,0,0,8'h5A);
    vecs[8]  = mk(0,0,0,0,16'h0000,8'h00,16'h2006, 16'h23C0,1,8'h77,1,0,0,8'h5A);
    vecs[9]  = mk(0,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,1,0,0,8'h5A);
    vecs[10] = mk(0,0,1,0,16'h23C0,8'h00,16'h2006, 16'h2006,0,8'h00,0,1,0,8'h5A);
    vecs[11] = mk(0,0,0,0,16'h0000,8'h00,16'h2006, 16'h23C0,0,8'h00,1,0,0,8'h5A);
    vecs[12] = mk(0,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,1,0,0,8'h5A);
    vecs[13] = mk(0,0,0,0,16'h0000,8'h00,16'h2006, 16'h2006,0,8'h00,0,1,0,8'h77);
    vecs[14] = mk(0,0,1,0,16'h2003,8'h00,16'h2007, 16'h2007,0,8'h00,0,0,0,8'h77);
    vecs[15] = mk(0,0,1,0,16'h2004,8'h00,16'h2007, 16'h2003,0,8'h00,1,0,0,8'h77);
    vecs[16] = mk(0,0,0,0,16'h0000,8'h00,16'h2007, 16'h2007,0,8'h00,1,0,1,8'h77);
    vecs[17] = mk(0,0,0,0,16'h0000,8'h00,16'h2007, 16'h2007,0,8'h00,0,1,1,8'h36);
    vecs[18] = mk(0,0,0,0,16'h0000,8'h00,16'h2007, 16'h2007,0,8'h00,0,0,1,8'h36);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].rr, vecs[i].ra, vecs[i].cr, vecs[i].cw,
                    vecs[i].ca, vecs[i].cd, vecs[i].radr);
      checkOutput($sformatf("tbl[%0d] vram_addr", i), vram_addr, vecs[i].e_addr);
      checkOutput($sformatf("tbl[%0d] vram_we", i), vram_we, vecs[i].e_we);
      if (vecs[i].e_we) checkOutput($sformatf("tbl[%0d] vram_din", i), vram_din, vecs[i].e_din);
      checkOutput($sformatf("tbl[%0d] busy", i), cpu_busy, vecs[i].e_busy);
      checkOutput($sformatf("tbl[%0d] ack", i), cpu_ack, vecs[i].e_ack);
      checkOutput($sformatf("tbl[%0d] overrun", i), cpu_overrun, vecs[i].e_ovr);
      checkOutput($sformatf("tbl[%0d] rdata", i), cpu_rdata, vecs[i].e_rdata);
    end

    // ---- starvation: renderer toggles inside a visible window ----
    doReset();
    applyStimulus(0, 1, 1, 0, 16'h2002, 8'h00, 16'h2009);
    waited = 0; granted = 1'b0; gcyc = -10;
    for (int c = 1; c < 60; c++) begin
      rr = c[0];
      applyStimulus(rr, 1, 0, 0, 16'h0, 8'h0, 16'h2009);
      eg = !granted && !rr && (waited >= STARVE_LIMIT);
      checkOutput($sformatf("starve grant c%0d", c), (vram_addr == 16'h2002), eg);
      checkOutput("starve vram_we", vram_we, 0);
      if (eg) begin
        granted = 1'b1;
        gcyc    = c;
      end else if (!granted && waited < STARVE_LIMIT) begin
        waited++;
      end
      if (granted && c == gcyc + 2) begin
        checkOutput("starve ack", cpu_ack, 1);
        checkOutput("starve rdata", cpu_rdata, 8'h25);
      end
    end
    checkOutput("starve granted", granted, 1);

    // ---- back-to-back: a new request in every ACK cycle ----
    doReset();
    prev_rr = 1'b0;
    for (int c = 0; c < 27; c++) begin
      k  = c / 3;
      rr = (c % 3) != 1;
      cr = ((c % 3) == 0) && (c <= 21);
      cw = (k % 2) == 0;
      ca = 16'h2008 + 16'(k / 2);
      cd = 8'hA0 + 8'(k);
      applyStimulus(rr, 0, cr, cw, ca, cd, 16'h200F);
      checkOutput("b2b rnd_valid", rnd_valid, prev_rr);
      checkOutput("b2b overrun", cpu_overrun, 0);
      ea = ((c % 3) == 0) && (c >= 3) && (c <= 24);
      checkOutput($sformatf("b2b ack c%0d", c), cpu_ack, ea);
      if (ea && (((k - 1) % 2) == 1)) checkOutput("b2b rdata", cpu_rdata, 8'hA0 + 8'(k - 2));
      prev_rr = rr;
    end

    // ---- reset with a write pending: no write, outputs drop immediately ----
    doReset();
    applyStimulus(1, 0, 1, 1, 16'h200A, 8'hEE, 16'h200C);
    for (int c = 0; c < 3; c++) applyStimulus(1, 0, 0, 0, 16'h0, 8'h0, 16'h200C);
    checkOutput("prst busy before", cpu_busy, 1);
    rnd_req = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("prst vram_we", vram_we, 0);
    checkOutput("prst busy", cpu_busy, 0);
    checkOutput("prst ack", cpu_ack, 0);
    checkOutput("prst vram_addr", vram_addr, 16'h200C);
    checkOutput("prst rnd_valid", rnd_valid, 0);
    @(negedge VGA_CLK);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(0, 0, 0, 0, 16'h0, 8'h0, 16'h200C);
      checkOutput("prst ack after", cpu_ack, 0);
      checkOutput("prst we after", vram_we, 0);
    end
    checkOutput("prst mem untouched", mem[16'h200A], 8'hAD);

    // ---- reset mid-WAIT of a read: no ack, read data discarded ----
    doReset();
    applyStimulus(0, 0, 1, 0, 16'h2001, 8'h00, 16'h200C);
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0, 16'h200C);
    applyStimulus(0, 0, 0, 0, 16'h0, 8'h0, 16'h200C);
    checkOutput("wrst busy before", cpu_busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("wrst busy", cpu_busy, 0);
    checkOutput("wrst ack", cpu_ack, 0);
    @(negedge VGA_CLK);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 0, 0, 0, 16'h0, 8'h0, 16'h200C);
      checkOutput("wrst ack after", cpu_ack, 0);
      checkOutput("wrst rdata", cpu_rdata, 0);
    end

    // ---- randomized traffic against a transaction-level model ----
    doReset();
    m_valid = 1'b0; m_we = 1'b0; m_granted = 1'b0; m_ovr = 1'b0;
    m_addr = '0; m_data = '0; m_rdata = '0; m_waited = 0; m_gcyc = 0;
    prev_rr = 1'b0; prev_radr = '0; ra = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 19) == 0) ra = ~ra;
      rr   = ($urandom_range(0, 2) == 0);
      cr   = ($urandom_range(0, 3) == 0);
      cw   = 1'($urandom_range(0, 1));
      ca   = 16'h2000 + 16'($urandom_range(0, 15));
      cd   = 8'($urandom);
      radr = 16'h2000 + 16'($urandom_range(0, 15));
      applyStimulus(rr, ra, cr, cw, ca, cd, radr);

      eg = m_valid && !m_granted && !rr && (!ra || (m_waited >= STARVE_LIMIT));
      ea = m_valid && m_granted && (cyc == m_gcyc + 2);
      eb = m_valid && !ea;
      checkOutput("rand vram_addr", vram_addr, eg ? m_addr : radr);
      checkOutput("rand vram_we", vram_we, eg && m_we);
      if (eg && m_we) checkOutput("rand vram_din", vram_din, m_data);
      checkOutput("rand busy", cpu_busy, eb);
      checkOutput("rand ack", cpu_ack, ea);
      checkOutput("rand overrun", cpu_overrun, m_ovr);
      checkOutput("rand rdata", cpu_rdata, m_rdata);
      checkOutput("rand rnd_valid", rnd_valid, prev_rr);
      if (prev_rr) checkOutput("rand rnd_data", rnd_data, ref_mem[prev_radr]);

      if (m_valid && m_granted && (cyc == m_gcyc + 1) && !m_we) m_rdata = ref_mem[m_addr];
      if (eg) begin
        m_granted = 1'b1;
        m_gcyc    = cyc;
        if (m_we) ref_mem[m_addr] = m_data;
      end else if (m_valid && !m_granted && (m_waited < STARVE_LIMIT)) begin
        m_waited++;
      end
      if (ea) m_valid = 1'b0;
      if (cr) begin
        if (!m_valid) begin
          m_valid   = 1'b1;
          m_granted = 1'b0;
          m_waited  = 0;
          m_we      = cw;
          m_addr    = ca;
          m_data    = cd;
        end else begin
          m_ovr = 1'b1;
        end
      end
      prev_rr   = rr;
      prev_radr = radr;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
